pipe_ctrl: RTL and testbench

Central hazard and sequencing controller for the five-stage pipeline. It drives the enable (hold) and flush (bubble) controls of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves four conditions: load-use hazards, taken branch/jump redirects from EX, data-memory wait states, and multi-cycle EX operations. It also keeps a stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 32 +++
 rtl/pipe_ctrl_if.sv | 40 ++++
 rtl/pipe_ctrl_hazard_detect.sv | 22 ++
 rtl/pipe_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    PC_RUN      = 2'd0,
    PC_MEM_WAIT = 2'd1,
    PC_MC_WAIT  = 2'd2
  } pc_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } ctl_t;

  localparam ctl_t CTL_DEF   = 8'b11111_000;
  localparam ctl_t CTL_HOLD  = 8'b00000_000;
  localparam ctl_t CTL_RST   = 8'b00000_111;
  localparam ctl_t CTL_LU    = 8'b00111_010;
  localparam ctl_t CTL_REDIR = 8'b11111_110;
  localparam ctl_t CTL_MC    = 8'b00011_001;
  // Leaving a memory wait while the multi-cycle op is still running: only MEM/WB drains.
  localparam ctl_t CTL_MC_GO = 8'b00001_000;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side status inputs and register control outputs of pipe_ctrl.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_is_load;
  logic             ex_pc_sel;
  logic             ex_mc_start;
  logic             ex_mc_done;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic [31:0]      stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_pc_sel, ex_mc_start, ex_mc_done, mem_req, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_pc_sel, ex_mc_start, ex_mc_done, mem_req, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, stall_cycles
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use compare between the ID sources and the load in EX.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic             i_use_rs1,
  input  logic             i_use_rs2,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_is_load,
  output logic             o_hazard
);

  logic w_hit1;
  logic w_hit2;

  assign w_hit1   = i_use_rs1 & (i_rs1 == i_ex_rd);
  assign w_hit2   = i_use_rs2 & (i_rs2 == i_ex_rd);
  // x0 is never written, so a load targeting it cannot create a dependency.
  assign o_hazard = i_ex_is_load & (i_ex_rd != {REG_W{1'b0}}) & (w_hit1 | w_hit2);

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller: PC/pipeline-register enables and flushes, stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  pipe_ctrl_if.slave  bus
);

  pc_state_e   r_state;
  pc_state_e   w_state_nxt;
  logic        r_mc_pend;
  logic        w_mc_pend_nxt;
  logic        r_done_seen;
  logic        w_done_seen_nxt;
  logic [31:0] r_stall;
  logic        w_hazard;
  logic        w_mem_wait;
  logic        w_mc_fin;
  ctl_t        w_ctl;

  pipe_ctrl_hazard_detect u_hazard (
    .i_rs1        (bus.id_rs1),
    .i_rs2        (bus.id_rs2),
    .i_use_rs1    (bus.id_use_rs1),
    .i_use_rs2    (bus.id_use_rs2),
    .i_ex_rd      (bus.ex_rd),
    .i_ex_is_load (bus.ex_is_load),
    .o_hazard     (w_hazard)
  );

  assign w_mem_wait = bus.mem_req & ~bus.mem_ready;
  assign w_mc_fin   = ~r_mc_pend | r_done_seen | bus.ex_mc_done;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= PC_RUN;
      r_mc_pend   <= 1'b0;
      r_done_seen <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mc_pend   <= w_mc_pend_nxt;
      r_done_seen <= w_done_seen_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mc_pend_nxt   = r_mc_pend;
    w_done_seen_nxt = r_done_seen;
    case (r_state)
      PC_RUN: begin
        if (w_mem_wait) begin
          w_state_nxt = PC_MEM_WAIT;
        end else if (bus.ex_mc_start & ~bus.ex_mc_done) begin
          w_state_nxt   = PC_MC_WAIT;
          w_mc_pend_nxt = 1'b1;
        end else begin
          w_state_nxt = PC_RUN;
        end
      end
      PC_MC_WAIT: begin
        // A done pulse coincident with a memory stall must not be lost.
        if (w_mem_wait) begin
          w_state_nxt     = PC_MEM_WAIT;
          w_done_seen_nxt = bus.ex_mc_done;
        end else if (bus.ex_mc_done) begin
          w_state_nxt   = PC_RUN;
          w_mc_pend_nxt = 1'b0;
        end else begin
          w_state_nxt = PC_MC_WAIT;
        end
      end
      PC_MEM_WAIT: begin
        if (bus.mem_ready) begin
          w_done_seen_nxt = 1'b0;
          if (w_mc_fin) begin
            w_state_nxt   = PC_RUN;
            w_mc_pend_nxt = 1'b0;
          end else begin
            w_state_nxt = PC_MC_WAIT;
          end
        end else begin
          w_done_seen_nxt = r_done_seen | bus.ex_mc_done;
        end
      end
      default: begin
        w_state_nxt     = PC_RUN;
        w_mc_pend_nxt   = 1'b0;
        w_done_seen_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_ctl = CTL_DEF;
    if (sys_rst) begin
      w_ctl = CTL_RST;
    end else begin
      case (r_state)
        PC_RUN: begin
          if (w_mem_wait) begin
            w_ctl = CTL_HOLD;
          end else if (bus.ex_mc_start & ~bus.ex_mc_done) begin
            w_ctl = CTL_MC;
          end else if (bus.ex_mc_start) begin
            w_ctl = CTL_DEF;
          end else if (bus.ex_pc_sel) begin
            w_ctl = CTL_REDIR;
          end else if (w_hazard) begin
            w_ctl = CTL_LU;
          end else begin
            w_ctl = CTL_DEF;
          end
        end
        PC_MC_WAIT: begin
          if (w_mem_wait) begin
            w_ctl = CTL_HOLD;
          end else if (bus.ex_mc_done) begin
            w_ctl = CTL_DEF;
          end else begin
            w_ctl = CTL_MC;
          end
        end
        PC_MEM_WAIT: begin
          if (!bus.mem_ready) begin
            w_ctl = CTL_HOLD;
          end else if (w_mc_fin) begin
            w_ctl = CTL_DEF;
          end else begin
            w_ctl = CTL_MC_GO;
          end
        end
        default: begin
          w_ctl = CTL_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_stall <= 32'd0;
    end else if (!w_ctl.pc_en) begin
      r_stall <= r_stall + 32'd1;
    end else begin
      r_stall <= r_stall;
    end
  end

  assign bus.pc_en        = w_ctl.pc_en;
  assign bus.ifid_en      = w_ctl.ifid_en;
  assign bus.idex_en      = w_ctl.idex_en;
  assign bus.exmem_en     = w_ctl.exmem_en;
  assign bus.memwb_en     = w_ctl.memwb_en;
  assign bus.ifid_flush   = w_ctl.ifid_flush;
  assign bus.idex_flush   = w_ctl.idex_flush;
  assign bus.exmem_flush  = w_ctl.exmem_flush;
  assign bus.stall_cycles = r_stall;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, corner sequences, randomized model compare.
module tb_pipe_ctrl;

  // Expected control words, bit order {pc,ifid,idex,exmem,memwb,ifid_f,idex_f,exmem_f}.
  localparam logic [7:0] E_DEF   = 8'b11111000;
  localparam logic [7:0] E_HOLD  = 8'b00000000;
  localparam logic [7:0] E_RST   = 8'b00000111;
  localparam logic [7:0] E_LU    = 8'b00111010;
  localparam logic [7:0] E_REDIR = 8'b11111110;
  localparam logic [7:0] E_MC    = 8'b00011001;
  localparam logic [7:0] E_MCGO  = 8'b00001000;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       sel;
    logic       ms;
    logic       md;
    logic       mr;
    logic       my;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      s;
    logic [7:0] exp;
  } vec_t;

  logic  clk;
  logic  rst;
  int    n_checks;
  int    n_err;
  logic [31:0] exp_stall;
  vec_t  vt[12];

  // Reference model state: what the pipeline is currently waiting for.
  bit    m_mem_blocked;
  bit    m_mc_busy;
  bit    m_done_seen;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t st(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                               input logic u2, input logic [4:0] rd, input logic ld,
                               input logic sel, input logic ms, input logic md,
                               input logic mr, input logic my);
    stim_t s;
    s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.rd = rd; s.ld = ld;
    s.sel = sel; s.ms = ms; s.md = md; s.mr = mr; s.my = my;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.id_rs1      = s.rs1;
    bus.id_rs2      = s.rs2;
    bus.id_use_rs1  = s.u1;
    bus.id_use_rs2  = s.u2;
    bus.ex_rd       = s.rd;
    bus.ex_is_load  = s.ld;
    bus.ex_pc_sel   = s.sel;
    bus.ex_mc_start = s.ms;
    bus.ex_mc_done  = s.md;
    bus.mem_req     = s.mr;
    bus.mem_ready   = s.my;
    #2;
  endtask

  task automatic check_ctl(input string nm, input logic [7:0] exp);
    logic [7:0] got;
    got = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
           bus.ifid_flush, bus.idex_flush, bus.exmem_flush};
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: controls got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_cnt(input string nm);
    n_checks++;
    if (bus.stall_cycles !== exp_stall) begin
      n_err++;
      $display("FAIL %s: stall_cycles got %0d expected %0d", nm, bus.stall_cycles, exp_stall);
    end
  endtask

  // Check expected controls, advance one clock, account for the stall.
  task automatic step(input string nm, input stim_t s, input logic [7:0] exp);
    apply(s);
    check_ctl(nm, exp);
    @(posedge clk);
    #1;
    if (exp[7] == 1'b0) exp_stall = exp_stall + 32'd1;
    check_cnt({nm, "_cnt"});
  endtask

  function automatic bit load_use(input stim_t s);
    return s.ld && (s.rd != 5'd0) &&
           ((s.u1 && (s.rs1 == s.rd)) || (s.u2 && (s.rs2 == s.rd)));
  endfunction

  // Higher-level rule model: returns expected controls and updates the wait bookkeeping.
  function automatic logic [7:0] model(input stim_t s);
    bit stalled_mem;
    logic [7:0] e;
    stalled_mem = s.mr && !s.my;
    if (m_mem_blocked) begin
      if (!s.my) begin
        e = E_HOLD;
        m_done_seen = m_done_seen || s.md;
      end else begin
        m_mem_blocked = 1'b0;
        if (!m_mc_busy || m_done_seen || s.md) begin
          e = E_DEF;
          m_mc_busy = 1'b0;
        end else begin
          e = E_MCGO;
        end
        m_done_seen = 1'b0;
      end
    end else if (m_mc_busy) begin
      if (stalled_mem) begin
        e = E_HOLD;
        m_mem_blocked = 1'b1;
        m_done_seen = s.md;
      end else if (s.md) begin
        e = E_DEF;
        m_mc_busy = 1'b0;
      end else begin
        e = E_MC;
      end
    end else begin
      if (stalled_mem) begin
        e = E_HOLD;
        m_mem_blocked = 1'b1;
      end else if (s.ms && !s.md) begin
        e = E_MC;
        m_mc_busy = 1'b1;
      end else if (s.ms) e = E_DEF;
      else if (s.sel) e = E_REDIR;
      else if (load_use(s)) e = E_LU;
      else e = E_DEF;
    end
    return e;
  endfunction

  initial begin
    stim_t idle;
    stim_t r;
    logic [7:0] e;
    n_checks  = 0;
    n_err     = 0;
    exp_stall = 32'd0;
    idle = st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    vt[0]  = '{"idle",       idle,                                                          E_DEF};
    vt[1]  = '{"lu_rs2",     st(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), E_LU};
    vt[2]  = '{"lu_rs1",     st(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), E_LU};
    vt[3]  = '{"rd_x0",      st(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), E_DEF};
    vt[4]  = '{"rs1_unused", st(5'd9, 5'd3, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), E_DEF};
    vt[5]  = '{"not_load",   st(5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), E_DEF};
    vt[6]  = '{"redirect",   st(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), E_REDIR};
    vt[7]  = '{"redir_lu",   st(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), E_REDIR};
    vt[8]  = '{"mc_single",  st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1), E_DEF};
    vt[9]  = '{"stray_done", st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), E_DEF};
    vt[10] = '{"mem_ready",  st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), E_DEF};
    vt[11] = '{"lu_31",      st(5'd31, 5'd6, 1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), E_LU};

    // Reset state
    rst = 1'b1;
    apply(idle);
    repeat (2) @(posedge clk);
    #1;
    check_ctl("reset_ctl", E_RST);
    check_cnt("reset_cnt");
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(vt[i].name, vt[i].s, vt[i].exp);
    end

    // Memory wait of three cycles, released on the fourth
    r = idle; r.mr = 1'b1; r.my = 1'b0;
    for (int i = 0; i < 3; i++) step("memw_hold", r, E_HOLD);
    r.my = 1'b1;
    step("memw_release", r, E_DEF);
    step("memw_after", idle, E_DEF);

    // Four-cycle multi-cycle op: three stall cycles
    r = idle; r.ms = 1'b1;
    step("mc_start", r, E_MC);
    step("mc_wait1", idle, E_MC);
    step("mc_wait2", idle, E_MC);
    r = idle; r.md = 1'b1;
    step("mc_done", r, E_DEF);
    step("mc_after", idle, E_DEF);

    // MC in progress, two-cycle mem wait, done during the wait
    r = idle; r.ms = 1'b1;
    step("mcm_start", r, E_MC);
    r = idle; r.mr = 1'b1; r.my = 1'b0;
    step("mcm_memw1", r, E_HOLD);
    r.md = 1'b1;
    step("mcm_memw2_done", r, E_HOLD);
    r = idle; r.mr = 1'b1;
    step("mcm_release", r, E_DEF);
    step("mcm_after", idle, E_DEF);

    // MC in progress, mem wait, no done yet: back to MC wait
    r = idle; r.ms = 1'b1;
    step("mcn_start", r, E_MC);
    r = idle; r.mr = 1'b1; r.my = 1'b0;
    step("mcn_memw", r, E_HOLD);
    step("mcn_release", idle, E_MCGO);
    step("mcn_wait", idle, E_MC);
    r = idle; r.md = 1'b1;
    step("mcn_done", r, E_DEF);

    // Reset pulse mid-MC
    r = idle; r.ms = 1'b1;
    step("rst_mc_start", r, E_MC);
    rst = 1'b1;
    apply(idle);
    check_ctl("rst_mid_ctl", E_RST);
    @(posedge clk);
    #1;
    exp_stall = 32'd0;
    check_cnt("rst_mid_cnt");
    rst = 1'b0;
    step("rst_after_run", idle, E_DEF);

    // Randomized run against the reference model
    m_mem_blocked = 1'b0;
    m_mc_busy     = 1'b0;
    m_done_seen   = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r.rs1 = 5'($urandom_range(0, 3));
      r.rs2 = 5'($urandom_range(0, 3));
      r.rd  = 5'($urandom_range(0, 3));
      r.u1  = 1'($urandom_range(0, 1));
      r.u2  = 1'($urandom_range(0, 1));
      r.ld  = ($urandom_range(0, 9) < 4);
      r.sel = ($urandom_range(0, 9) < 2);
      r.ms  = ($urandom_range(0, 9) < 1);
      r.md  = ($urandom_range(0, 9) < 2);
      r.mr  = ($urandom_range(0, 9) < 5);
      r.my  = ($urandom_range(0, 9) < 6);
      e = model(r);
      step("random", r, e);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
